// File: rtl/alu_cmd_dispatch.sv
// Command dispatcher for a dual-set ALU: queues commands in a small FIFO,
// issues them one at a time and returns each result with its caller tag.

package alu_cmd_pkg;

    // Which ALU opcode set a command targets; 00 is rejected with res_err.
    typedef enum logic [1:0] {
        MODE_ILLEGAL = 2'b00,
        MODE_A       = 2'b01,
        MODE_B1      = 2'b10,
        MODE_B2      = 2'b11
    } mode_e;

    // A-set opcodes, carried on a_op.
    typedef enum logic [2:0] {
        ADD_A  = 3'd0,
        SUB_A  = 3'd1,
        AND_A  = 3'd2,
        OR_A   = 3'd3,
        XOR_A  = 3'd4,
        NOT_A  = 3'd5,
        MOVA_A = 3'd6,
        MOVB_A = 3'd7
    } a_op_e;

    // B-set-2 opcodes, carried on b_op (low two bits of cmd_op).
    typedef enum logic [1:0] {
        ADD_B_2    = 2'd0,
        SUB_B_2    = 2'd1,
        ADDTWO_B_2 = 2'd2,
        NEG_B_2    = 2'd3
    } b_op_e;

    // One queued command.
    typedef struct packed {
        logic [1:0] mode;
        logic [2:0] op;
        logic [4:0] a;
        logic [4:0] b;
        logic [2:0] tag;
    } cmd_t;

endpackage

module alu_cmd_dispatch
    import alu_cmd_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_mode,
    input  logic [2:0]               cmd_op,
    input  logic [4:0]               cmd_a,
    input  logic [4:0]               cmd_b,
    input  logic [2:0]               cmd_tag,
    output logic                     a_en,
    output logic                     b_en,
    output logic [2:0]               a_op,
    output logic [1:0]               b_op,
    output logic [4:0]               A,
    output logic [4:0]               B,
    input  logic [5:0]               C,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [5:0]               res_data,
    output logic [2:0]               res_tag,
    output logic                     res_err,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

    state_e        state_q, state_d;
    cmd_t          mem [DEPTH];
    cmd_t          cmd_in;
    cmd_t          head;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          push, pop;
    logic [1:0]    cur_mode;
    logic [2:0]    cur_tag;

    assign cmd_in    = {cmd_mode, cmd_op, cmd_a, cmd_b, cmd_tag};
    assign head      = mem[rd_ptr];
    assign cmd_ready = (fifo_count != CW'(DEPTH));
    assign push      = cmd_valid && cmd_ready;

    // FIFO storage write port.
    // NOTE: storage is not reset; an entry is only read after it has been
    // written, and the pointers/count carry the reset state.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= cmd_in;
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FSM next state and FIFO pop decision.
    // NOTE: every output of this block gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (fifo_count != '0) begin
                    pop     = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT:  state_d = RESP;
            RESP: begin
                if (res_ready) begin
                    if (fifo_count != '0) begin
                        pop     = 1'b1;
                        state_d = ISSUE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ALU drive on issue and result capture at the end of WAIT.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_en      <= 1'b0;
            b_en      <= 1'b0;
            a_op      <= '0;
            b_op      <= '0;
            A         <= '0;
            B         <= '0;
            cur_mode  <= '0;
            cur_tag   <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_tag   <= '0;
            res_err   <= 1'b0;
        end else begin
            // Enables pulse for the single ISSUE cycle only.
            a_en <= 1'b0;
            b_en <= 1'b0;
            if (pop) begin
                A        <= head.a;
                B        <= head.b;
                a_op     <= head.op;
                b_op     <= head.op[1:0];
                a_en     <= head.mode[0];
                b_en     <= head.mode[1];
                cur_mode <= head.mode;
                cur_tag  <= head.tag;
            end
            if (state_q == WAIT) begin
                res_valid <= 1'b1;
                res_tag   <= cur_tag;
                if (cur_mode == MODE_ILLEGAL) begin
                    res_data <= '0;
                    res_err  <= 1'b1;
                end else begin
                    res_data <= C;
                    res_err  <= 1'b0;
                end
            end else if (state_q == RESP && res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/alu_cmd_dispatch.md
ALU_CMD_DISPATCH -- requirements
Module: alu_cmd_dispatch

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning command FIFO entries (power of two, >=2).
REQ-002 The block SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 The block SHALL have port cmd_valid  input  1  command offered.
REQ-005 The block SHALL have port cmd_ready  output  1  command FIFO not full.
REQ-006 The block SHALL have port cmd_mode  input  2  01=A-set, 10=B-set-1, 11=B-set-2, 00=illegal.
REQ-007 The block SHALL have port cmd_op  input  3  opcode; shared-package a_op value, low 2 bits used as b_op.
REQ-008 The block SHALL have port cmd_a  input  5  signed operand A.
REQ-009 The block SHALL have port cmd_b  input  5  signed operand B.
REQ-010 The block SHALL have port cmd_tag  input  3  caller tag, returned with result.
REQ-011 The block SHALL have ports a_en, b_en  output  1 each  ALU enables, registered.
REQ-012 The block SHALL have ports a_op  output  3  and b_op  output  2  ALU opcodes, registered.
REQ-013 The block SHALL have ports A, B  output  5 each  ALU operands, registered.
REQ-014 The block SHALL have port C  input  6  ALU result, valid the cycle after enables sampled.
REQ-015 The block SHALL have ports res_valid  output  1, res_ready  input  1  result handshake.
REQ-016 The block SHALL have ports res_data  output  6, res_tag  output  3, res_err  output  1  result payload.
REQ-017 The block SHALL have port fifo_count  output  $clog2(DEPTH)+1  queued entries.

Function
REQ-018 The FIFO SHALL push on cmd_valid&&cmd_ready; cmd_ready SHALL equal (fifo_count!=DEPTH), independent of same-cycle pop.
REQ-019 The FIFO SHALL preserve order; read/write pointers wrap modulo DEPTH; push and pop in the same cycle leave fifo_count unchanged.
REQ-020 The FSM SHALL have states IDLE, ISSUE, WAIT, RESP.
REQ-021 IDLE: if fifo_count!=0, pop head, load A/B/a_op/b_op/tag, go ISSUE; else stay.
REQ-022 ISSUE (exactly one cycle): a_en=cmd_mode[0], b_en=cmd_mode[1]; go WAIT.
REQ-023 WAIT (one cycle): a_en=b_en=0; at cycle end capture res_data=C (res_data=0 and res_err=1 if mode was 00), go RESP.
REQ-024 RESP: res_valid=1, payload stable until res_valid&&res_ready; on handshake pop and go ISSUE if FIFO non-empty, else IDLE.
REQ-025 a_en/b_en SHALL be high only in ISSUE; A/B/a_op/b_op SHALL hold last issued values otherwise.
REQ-026 Mode 00 SHALL traverse ISSUE/WAIT with both enables low and SHALL NOT stall the queue.
REQ-027 Latency: command accepted into empty FIFO with FSM in IDLE at edge t -> res_valid high from edge t+3.
REQ-028 Sustained throughput with res_ready=1: one result per 3 cycles.
REQ-029 res_data SHALL be C verbatim (6-bit, no re-extension or truncation).

Reset
REQ-030 On rst_n low, asynchronously: FSM=IDLE, FIFO empty, fifo_count=0, a_en=b_en=0, a_op=b_op=0, A=B=0, res_valid=0, res_data=0, res_tag=0, res_err=0.
REQ-031 Reset mid-operation (any state) SHALL discard queued and in-flight commands; no result for them after release.
REQ-032 cmd_ready SHALL be 1 from the first cycle after rst_n deasserts.

Verification
REQ-033 mode=01, op=ADD_A, A=7, B=3, tag=2 into idle block -> a_en=1,b_en=0 for one cycle; res_valid at t+3, res_data=6'd10, res_tag=2, res_err=0.
REQ-034 mode=01, op=SUB_A, A=5'b10000 (-16), B=1 -> res_data=6'b101111 (-17).
REQ-035 res_ready=0, cmd_valid held with tags 0..7 -> exactly DEPTH+1=5 accepted, cmd_ready=0, fifo_count=4; then res_ready=1 -> results tags 0,1,2,3,4 in order, 3 cycles apart.
REQ-036 mode=00, tag=5 -> a_en=b_en=0 throughout; res_valid with res_err=1, res_data=0, res_tag=5; next queued command issues normally.
REQ-037 rst_n pulsed low during WAIT with 2 queued -> all outputs reset values immediately; after release fifo_count=0, res_valid stays 0.
REQ-038 mode=11, op=ADDTWO_B_2, B=5'd30 (-2) -> a_en=b_en=1 one cycle, res_data=6'd0.
